// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared encodings for the pipeline interlock controller.
//   REGADDR_WIDTH / WB_SRC_*  : register-address width and writeback-source codes
//   hz_state_e                : interlock FSM state encodings
//   wait_cnt_width()          : width needed to count up to a timeout value
package hazard_unit_pkg;

    localparam int REGADDR_WIDTH = 5;
    localparam int WB_SRC_WIDTH  = 2;

    localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_ALU = 2'd0;
    localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_MEM = 2'd1;
    localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_PC  = 2'd2;

    typedef enum logic {
        HZ_STATE_IDLE     = 1'b0,
        HZ_STATE_MEM_WAIT = 1'b1
    } hz_state_e;

    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: WIDTH-bit up-counter that sticks at all-ones.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear (wins over inc_i)
//   inc_i    : increment request
//   cnt_o    : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline interlock controller for the 5-stage core.
//   Inputs : ID source regs/uses, EX-stage wb source/destination,
//            mem_req/mem_ack handshake of the MEM stage, branch_taken from EX.
//   Outputs: per-stage stall/bubble/flush controls (combinational),
//            mem_timeout watchdog pulse and stall_cycles perf counter (registered).
// Priority: memory freeze > branch flush > load-use bubble.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REGADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REGADDR_WIDTH-1:0] id_rt_addr,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic [WB_SRC_WIDTH-1:0]  id2ex_wb_src,
    input  logic [REGADDR_WIDTH-1:0] id2ex_wb_reg_addr,
    input  logic                     mem_req,
    input  logic                     mem_ack,
    input  logic                     branch_taken,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     bubble_ex,
    output logic                     stall_ex,
    output logic                     stall_mem,
    output logic                     flush_id,
    output logic                     mem_timeout,
    output logic [CNT_WIDTH-1:0]     stall_cycles
);

    localparam int                WAIT_W    = wait_cnt_width(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e            state_q, state_d;
    logic                 pend_q, pend_d;
    logic                 mto_q;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic load_use, freeze, wd_fire, flush;

    // Hazard detection
    always_comb begin
        load_use = (id2ex_wb_src == WB_SRC_MEM) &&
                   (id2ex_wb_reg_addr != '0) &&
                   ((id_uses_rs && (id_rs_addr == id2ex_wb_reg_addr)) ||
                    (id_uses_rt && (id_rt_addr == id2ex_wb_reg_addr)));
        // The last allowed MEM_WAIT cycle is still frozen; release happens
        // on the following cycle together with the timeout pulse.
        wd_fire  = (state_q == HZ_STATE_MEM_WAIT) && !mem_ack && (wait_cnt == WAIT_LAST);
        freeze   = !rst && !mem_ack && (mem_req || (state_q == HZ_STATE_MEM_WAIT));
        // A flush deferred by a freeze is delivered in the first unfrozen cycle.
        flush    = !rst && !freeze && (branch_taken || pend_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_STATE_IDLE;
            pend_q  <= 1'b0;
            mto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mto_q   <= wd_fire;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_STATE_IDLE:     if (mem_req && !mem_ack)  state_d = HZ_STATE_MEM_WAIT;
            HZ_STATE_MEM_WAIT: if (mem_ack || wd_fire)   state_d = HZ_STATE_IDLE;
            default:                                     state_d = HZ_STATE_IDLE;
        endcase

        pend_d = pend_q;
        if (freeze && branch_taken) pend_d = 1'b1;
        else if (!freeze)           pend_d = 1'b0;
    end

    // Output logic
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        if (freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (flush) begin
            // The squashed ID instruction needs no interlock.
            flush_id  = 1'b1;
        end else if (!rst && load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    assign mem_timeout  = mto_q && !rst;
    assign stall_cycles = rst ? '0 : stall_cnt;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (stall_if),
        .cnt_o (stall_cnt)
    );

    // Held at zero while idle so it starts from zero on MEM_WAIT entry.
    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == HZ_STATE_IDLE),
        .inc_i (state_q == HZ_STATE_MEM_WAIT),
        .cnt_o (wait_cnt)
    );

endmodule
